// File: rtl/key_led_pkg.sv
// Shared types for the key-to-LED front-panel controller.
package key_led_pkg;

    typedef enum logic [1:0] {
        LED_MIRROR  = 2'b00,
        LED_TOGGLE  = 2'b01,
        LED_STRETCH = 2'b10,
        LED_OFF     = 2'b11
    } led_mode_e;

endpackage

// File: rtl/key_led_if.sv
// Front-panel bundle: raw keys and mode in, debounced levels, pulses and LED drive out.
interface key_led_if
    import key_led_pkg::*;
#(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_n;
    led_mode_e         led_mode;
    logic [N_KEYS-1:0] pressed;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;
    logic [N_KEYS-1:0] led;

    modport master (
        output key_n, led_mode,
        input  pressed, press_pulse, release_pulse, led
    );

    modport slave (
        input  key_n, led_mode,
        output pressed, press_pulse, release_pulse, led
    );
endinterface

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchroniser, restart-on-bounce debounce counter,
// debounced level and registered press/release pulses.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_n_i,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          s;

    // Synchroniser resets to the released level so reset exit never looks like a press.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
        end
    end

    assign s = ~sync_q[1];

    always_comb begin
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s == pressed_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            pressed_d = s;
            press_d   = s;
            release_d = ~s;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign pressed_o       = pressed_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
endmodule

// File: rtl/key_led_ctrl.sv
// Key-to-LED controller: per-key debounce plus toggle / pulse-stretch state
// and a registered LED mode mux shared by all channels.
module key_led_ctrl
    import key_led_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STRETCH_CYCLES  = 25_000_000
) (
    input  logic    CLOCK_50,
    input  logic    RESET_N,
    key_led_if.slave bus
);
    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);

    logic [1:0]          rst_sync_q;
    logic                rst_n_int;
    logic [N_KEYS-1:0]   pressed_w, press_w, release_w;
    logic [N_KEYS-1:0]   toggle_q, toggle_d;
    logic [N_KEYS-1:0]   led_q, led_d;
    logic [SW-1:0]       stretch_q [N_KEYS];
    logic [SW-1:0]       stretch_d [N_KEYS];

    // Assert asynchronously, release two clocks after RESET_N rises.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i          (CLOCK_50),
            .rst_n_i        (rst_n_int),
            .key_n_i        (bus.key_n[g]),
            .pressed_o      (pressed_w[g]),
            .press_pulse_o  (press_w[g]),
            .release_pulse_o(release_w[g])
        );
    end

    always_comb begin
        toggle_d = toggle_q;
        led_d    = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            stretch_d[i] = stretch_q[i];
            if (press_w[i]) begin
                toggle_d[i]  = ~toggle_q[i];
                stretch_d[i] = STRETCH_LOAD;
            end else if (stretch_q[i] != '0) begin
                stretch_d[i] = stretch_q[i] - SW'(1);
            end
            case (bus.led_mode)
                LED_MIRROR:  led_d[i] = pressed_w[i];
                LED_TOGGLE:  led_d[i] = toggle_q[i];
                LED_STRETCH: led_d[i] = (stretch_q[i] != '0);
                default:     led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n_int) begin
        if (!rst_n_int) begin
            toggle_q <= '0;
            led_q    <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                stretch_q[i] <= '0;
            end
        end else begin
            toggle_q <= toggle_d;
            led_q    <= led_d;
            for (int i = 0; i < N_KEYS; i++) begin
                stretch_q[i] <= stretch_d[i];
            end
        end
    end

    assign bus.pressed       = pressed_w;
    assign bus.press_pulse   = press_w;
    assign bus.release_pulse = release_w;
    assign bus.led           = led_q;
endmodule
